// File: rtl/vdp18_spr_eval.sv
// vdp18_spr_eval: per-line sprite attribute scanner over a VRAM req/ack port.
// Optional VDP18_SPR_HITCNT_EN adds hit_cnt_o and scans past the first overflow.
module vdp18_spr_eval #(
  parameter int MAX_SPR_LINE = 4,
  parameter int NUM_SPR      = 32,
  parameter int CNT_W        = $clog2(MAX_SPR_LINE + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      clk_en_i,
  input  logic                      start_i,
  input  logic [7:0]                line_i,
  input  logic [6:0]                reg_satb_i,
  input  logic                      reg_size1_i,
  input  logic                      reg_mag1_i,
  output logic                      vram_req_o,
  output logic [13:0]               vram_a_o,
  input  logic                      vram_ack_i,
  input  logic [7:0]                vram_d_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [CNT_W-1:0]          spr_cnt_o,
  output logic [5*MAX_SPR_LINE-1:0] spr_num_o,
  output logic [4*MAX_SPR_LINE-1:0] spr_row_o,
`ifdef VDP18_SPR_HITCNT_EN
  output logic [5:0]                hit_cnt_o,
`endif
  output logic                      ovf_o,
  output logic [4:0]                ovf_num_o
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_SPR_LINE);
  localparam logic [4:0]       LAST  = 5'(NUM_SPR - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CHECK,
    DONE
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic                      got_q;
  logic [7:0]                y_q;
  logic [4:0]                num_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [5*MAX_SPR_LINE-1:0] nums_q;
  logic [4*MAX_SPR_LINE-1:0] rows_q;
  logic                      ovf_q;
  logic [4:0]                ovfn_q;
  logic                      done_q;
`ifdef VDP18_SPR_HITCNT_EN
  logic [5:0]                hit_q;
`endif

  logic [7:0] d;
  logic [8:0] h;
  logic       vis;
  logic [3:0] row;
  logic       term;
  logic       full;
  logic       last;
  logic       stop;

  // Y is top line minus one; everything wraps mod 256
  assign d    = line_i - (y_q + 8'd1);
  assign h    = 9'd8 << ({1'b0, reg_size1_i} + {1'b0, reg_mag1_i});
  assign vis  = {1'b0, d} < h;
  assign row  = reg_mag1_i ? d[4:1] : d[3:0];
  assign term = (y_q == 8'hD0);
  assign full = (cnt_q == MAX_C);
  assign last = (num_q == LAST);
`ifdef VDP18_SPR_HITCNT_EN
  assign stop = term || last;
`else
  assign stop = term || last || (vis && full);
`endif

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state; every move waits for an access slot
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (clk_en_i && start_i) state_d = REQ;
      REQ:   if (clk_en_i && (got_q || vram_ack_i)) state_d = CHECK;
      CHECK: if (clk_en_i) state_d = stop ? DONE : REQ;
      DONE:  if (clk_en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scan datapath: Y capture, slot fill, overflow tracking
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      got_q  <= 1'b0;
      y_q    <= '0;
      num_q  <= '0;
      cnt_q  <= '0;
      nums_q <= '0;
      rows_q <= '0;
      ovf_q  <= 1'b0;
      ovfn_q <= '0;
      done_q <= 1'b0;
`ifdef VDP18_SPR_HITCNT_EN
      hit_q  <= '0;
`endif
    end else begin
      done_q <= clk_en_i && (state_q == DONE);
      unique case (state_q)
        IDLE: if (clk_en_i && start_i) begin
          got_q  <= 1'b0;
          num_q  <= '0;
          cnt_q  <= '0;
          nums_q <= '0;
          rows_q <= '0;
          ovf_q  <= 1'b0;
          ovfn_q <= '0;
`ifdef VDP18_SPR_HITCNT_EN
          hit_q  <= '0;
`endif
        end
        REQ: begin
          if (vram_ack_i && !got_q) y_q <= vram_d_i;
          if (clk_en_i && (got_q || vram_ack_i)) got_q <= 1'b0;
          else if (vram_ack_i) got_q <= 1'b1;
        end
        CHECK: if (clk_en_i) begin
          if (term) begin
            if (!ovf_q) ovfn_q <= num_q;
          end else begin
            if (last && !ovf_q) ovfn_q <= num_q;
            if (vis) begin
`ifdef VDP18_SPR_HITCNT_EN
              hit_q <= hit_q + 6'd1;
`endif
              if (full) begin
                if (!ovf_q) begin
                  ovf_q  <= 1'b1;
                  ovfn_q <= num_q;
                end
              end else begin
                for (int s = 0; s < MAX_SPR_LINE; s++) begin
                  if (cnt_q == s[CNT_W-1:0]) begin
                    nums_q[s*5 +: 5] <= num_q;
                    rows_q[s*4 +: 4] <= row;
                  end
                end
                cnt_q <= cnt_q + 1'b1;
              end
            end
            if (!stop) num_q <= num_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign vram_req_o = (state_q == REQ) && !got_q;
  assign vram_a_o   = (state_q == REQ) ? {reg_satb_i, num_q, 2'b00} : '0;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign spr_cnt_o  = cnt_q;
  assign spr_num_o  = nums_q;
  assign spr_row_o  = rows_q;
  assign ovf_o      = ovf_q;
  assign ovf_num_o  = ovfn_q;
`ifdef VDP18_SPR_HITCNT_EN
  assign hit_cnt_o  = hit_q;
`endif

endmodule

// File: tb/tb_vdp18_spr_eval.sv
// tb_vdp18_spr_eval: directed table, corner sequences and random scans
// checked against a SAT-walking reference model.
module tb_vdp18_spr_eval;
  localparam int MAX = 4;
  localparam int NUM = 32;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        clk_en = 1;
  logic        start = 0;
  logic [7:0]  line = 0;
  logic [6:0]  satb = 7'h2A;
  logic        size1 = 0;
  logic        mag1 = 0;
  logic        req;
  logic [13:0] a;
  logic        ack = 0;
  logic [7:0]  vd = 0;
  logic        busy;
  logic        done;
  logic [2:0]  cnt;
  logic [19:0] nums;
  logic [15:0] rows;
  logic        ovf;
  logic [4:0]  ovfn;
`ifdef VDP18_SPR_HITCNT_EN
  logic [5:0]  hit;
`endif

  vdp18_spr_eval #(.MAX_SPR_LINE(MAX), .NUM_SPR(NUM)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .clk_en_i(clk_en), .start_i(start),
    .line_i(line), .reg_satb_i(satb), .reg_size1_i(size1),
    .reg_mag1_i(mag1), .vram_req_o(req), .vram_a_o(a),
    .vram_ack_i(ack), .vram_d_i(vd), .busy_o(busy), .done_o(done),
    .spr_cnt_o(cnt), .spr_num_o(nums), .spr_row_o(rows),
`ifdef VDP18_SPR_HITCNT_EN
    .hit_cnt_o(hit),
`endif
    .ovf_o(ovf), .ovf_num_o(ovfn)
  );

  always #5 clk = ~clk;

  logic [7:0] sat [NUM];
  int  ack_dly = 0;
  bit  en_div = 0;
  int  wcnt = 0;
  int  checks = 0;
  int  failures = 0;
  int  done_cnt = 0;
  int  done_err = 0;
  int  addr_err = 0;
  logic        p_req = 0;
  logic        p_done = 0;
  logic [13:0] p_a = 0;

  always @(posedge clk) begin
    if (req && !ack) begin
      if (wcnt >= ack_dly) begin
        ack  <= 1'b1;
        vd   <= sat[a[6:2]];
        wcnt <= 0;
      end else wcnt <= wcnt + 1;
    end else begin
      ack  <= 1'b0;
      wcnt <= 0;
    end
  end

  always @(posedge clk) clk_en <= en_div ? ~clk_en : 1'b1;

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (done && p_done) done_err <= done_err + 1;
    if (req && (a[13:7] != satb || a[1:0] != 2'b00)) addr_err <= addr_err + 1;
    if (req && p_req && a != p_a) addr_err <= addr_err + 1;
    p_req  <= req;
    p_a    <= a;
    p_done <= done;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  int          e_cnt, e_ovfn, e_hit;
  bit          e_ovf;
  logic [19:0] e_nums;
  logic [15:0] e_rows;

  task automatic model();
    logic [7:0] dd;
    int hgt;
    bit hitmode;
`ifdef VDP18_SPR_HITCNT_EN
    hitmode = 1;
`else
    hitmode = 0;
`endif
    e_cnt = 0; e_ovf = 0; e_ovfn = 0; e_hit = 0;
    e_nums = '0; e_rows = '0;
    hgt = 8 * (size1 ? 2 : 1) * (mag1 ? 2 : 1);
    for (int n = 0; n < NUM; n++) begin
      if (sat[n] == 8'hD0) begin
        if (!e_ovf) e_ovfn = n;
        break;
      end
      dd = line - sat[n] - 8'd1;
      if (int'(dd) < hgt) begin
        e_hit++;
        if (e_cnt == MAX) begin
          if (!e_ovf) begin
            e_ovf = 1;
            e_ovfn = n;
          end
          if (!hitmode) break;
        end else begin
          e_nums[e_cnt*5 +: 5] = 5'(n);
          e_rows[e_cnt*4 +: 4] = mag1 ? 4'(dd / 2) : 4'(dd);
          e_cnt++;
        end
      end
      if (n == NUM - 1 && !e_ovf) e_ovfn = n;
    end
  endtask

  task automatic run_scan(input string tag);
    int t;
    @(negedge clk);
    start = 1;
    t = 0;
    while (!busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    start = 0;
    chk({tag, " start"}, 32'(busy), 1);
    t = 0;
    while (!done && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " done"}, 32'(done), 1);
    model();
    chk({tag, " cnt"}, 32'(cnt), 32'(e_cnt));
    chk({tag, " ovf"}, 32'(ovf), 32'(e_ovf));
    chk({tag, " ovfn"}, 32'(ovfn), 32'(e_ovfn));
    chk({tag, " nums"}, 32'(nums), 32'(e_nums));
    chk({tag, " rows"}, 32'(rows), 32'(e_rows));
`ifdef VDP18_SPR_HITCNT_EN
    chk({tag, " hit"}, 32'(hit), 32'(e_hit));
`endif
  endtask

  typedef struct {
    logic [7:0] y;
    int n;
    int term;
    logic [7:0] ln;
    bit sz;
    bit mg;
    int e_cnt;
    bit e_ovf;
    int e_ovfn;
    int e_row0;
    int e_hit;
  } vec_t;

  vec_t tv [8];

  task automatic fill(input logic [7:0] y, input int n, input int term);
    for (int i = 0; i < NUM; i++) sat[i] = (i < n) ? y : 8'hC0;
    if (term >= 0) sat[term] = 8'hD0;
  endtask

  initial begin
    int t;
    int dc;
    tv[0] = '{8'hD0, 1, 0, 8'd10, 0, 0, 0, 0, 0, 0, 0};
    tv[1] = '{8'd9, 6, -1, 8'd10, 0, 0, 4, 1, 4, 0, 6};
    tv[2] = '{8'hFF, 1, 1, 8'd3, 1, 0, 1, 0, 1, 3, 1};
    tv[3] = '{8'hFF, 1, 1, 8'd16, 1, 0, 0, 0, 1, 0, 0};
    tv[4] = '{8'd20, 1, 1, 8'd36, 0, 1, 1, 0, 1, 7, 1};
    tv[5] = '{8'd20, 1, 1, 8'd37, 0, 1, 0, 0, 1, 0, 0};
    tv[6] = '{8'h00, 0, -1, 8'd10, 0, 0, 0, 0, 31, 0, 0};
    tv[7] = '{8'd5, 3, -1, 8'd10, 0, 0, 3, 0, 31, 4, 3};
    fill(8'hC0, 0, -1);

    repeat (3) @(negedge clk);
    chk("rst req", 32'(req), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst cnt", 32'(cnt), 0);
    chk("rst ovf", {27'd0, ovfn, 3'd0} | 32'(ovf), 0);
    chk("rst slots", 32'(nums) | 32'(rows), 0);
    rst_n = 1;

    for (int i = 0; i < 8; i++) begin
      fill(tv[i].y, tv[i].n, tv[i].term);
      line = tv[i].ln;
      size1 = tv[i].sz;
      mag1 = tv[i].mg;
      run_scan($sformatf("vec%0d", i));
      chk($sformatf("vec%0d k_cnt", i), 32'(cnt), 32'(tv[i].e_cnt));
      chk($sformatf("vec%0d k_ovf", i), 32'(ovf), 32'(tv[i].e_ovf));
      chk($sformatf("vec%0d k_ovfn", i), 32'(ovfn), 32'(tv[i].e_ovfn));
      chk($sformatf("vec%0d k_row0", i), 32'(rows[3:0]), 32'(tv[i].e_row0));
`ifdef VDP18_SPR_HITCNT_EN
      chk($sformatf("vec%0d k_hit", i), 32'(hit), 32'(tv[i].e_hit));
`endif
    end

    en_div = 1;
    ack_dly = 3;
    fill(8'd9, 6, -1);
    line = 10; size1 = 0; mag1 = 0;
    run_scan("slow");
    chk("slow nums", 32'(nums), 32'h18820);
    chk("slow rows", 32'(rows), 0);
    chk("slow ovfn", 32'(ovfn), 4);
    chk("addr stable", 32'(addr_err), 0);

    en_div = 0;
    ack_dly = 20;
    @(negedge clk);
    start = 1;
    t = 0;
    while (!req && t < 50) begin
      @(negedge clk);
      t++;
    end
    start = 0;
    chk("abort req seen", 32'(req), 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort req", 32'(req), 0);
    chk("abort busy", 32'(busy), 0);
    dc = done_cnt;
    repeat (6) @(negedge clk);
    chk("abort no done", 32'(done_cnt), 32'(dc));
    rst_n = 1;
    ack_dly = 0;

`ifdef VDP18_SPR_HITCNT_EN
    fill(8'd9, 8, 8);
    line = 10;
    run_scan("hit8");
    chk("hit8 hit", 32'(hit), 8);
    chk("hit8 cnt", 32'(cnt), 4);
    chk("hit8 ovfn", 32'(ovfn), 4);
`endif

    for (int r = 0; r < 25; r++) begin
      line = 8'($urandom);
      size1 = 1'($urandom);
      mag1 = 1'($urandom);
      ack_dly = $urandom_range(0, 2);
      en_div = 1'($urandom);
      for (int i = 0; i < NUM; i++) begin
        if ($urandom_range(0, 39) == 0) sat[i] = 8'hD0;
        else if ($urandom_range(0, 2) == 0)
          sat[i] = line - 8'($urandom_range(0, 34));
        else sat[i] = 8'($urandom);
      end
      run_scan($sformatf("rnd%0d", r));
    end

    chk("done width", 32'(done_err), 0);
    chk("addr final", 32'(addr_err), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
